// File: rtl/lint_arb_pkg.sv
// Shared types and constants for the 64-bit LINT arbiters.
// The request bundle is kept as one packed struct so the field mux is a single select.
package lint_arb_pkg;

    localparam int LINT64_DW  = 64;
    localparam int LINT_AW    = 32;
    localparam int LINT64_BEW = 8;

    typedef struct packed {
        logic [LINT64_DW-1:0]  wdata;
        logic [LINT_AW-1:0]    add;
        logic                  wen;
        logic [LINT64_BEW-1:0] be;
        logic                  size;
    } lint64_req_t;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_lock_e;

endpackage

// File: rtl/lint_id_fifo.sv
// In-order ID FIFO: remembers which initiator issued each outstanding transaction.
// Push is refused when full and pop when empty; a same-cycle pop never frees a slot for the push.
module lint_id_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_en;
    logic          pop_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/lint64_rr_arbiter.sv
// Round-robin arbiter sharing one 64-bit LINT target among N_MASTER initiators.
// Selection is locked while a request waits for grant so the downstream splitter sees stable fields.
module lint64_rr_arbiter
    import lint_arb_pkg::*;
#(
    parameter int N_MASTER  = 4,
    parameter int MAX_OUTST = 2,
    parameter int ID_W      = $clog2(N_MASTER)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_MASTER-1:0]                  m_req_i,
    output logic [N_MASTER-1:0]                  m_gnt_o,
    input  logic [N_MASTER-1:0][LINT64_DW-1:0]   m_wdata_i,
    input  logic [N_MASTER-1:0][LINT_AW-1:0]     m_add_i,
    input  logic [N_MASTER-1:0]                  m_wen_i,
    input  logic [N_MASTER-1:0][LINT64_BEW-1:0]  m_be_i,
    input  logic [N_MASTER-1:0]                  m_size_i,
    output logic [N_MASTER-1:0]                  m_r_valid_o,
    output logic [LINT64_DW-1:0]                 m_r_rdata_o,
    output logic                                 s_req_o,
    input  logic                                 s_gnt_i,
    output logic [LINT64_DW-1:0]                 s_wdata_o,
    output logic [LINT_AW-1:0]                   s_add_o,
    output logic                                 s_wen_o,
    output logic [LINT64_BEW-1:0]                s_be_o,
    output logic                                 s_size_o,
    input  logic                                 s_r_valid_i,
    input  logic [LINT64_DW-1:0]                 s_r_rdata_i,
    output logic                                 err_o
);

    lint64_req_t   m_bundle [N_MASTER];
    lint64_req_t   sel_req;

    logic [ID_W-1:0] rr_q, rr_d;
    arb_lock_e       lock_q, lock_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;
    logic            err_q, err_d;

    logic [ID_W-1:0] scan_id;
    logic            scan_found;
    int              scan_idx;
    logic [ID_W-1:0] winner;
    logic            handshake;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] fifo_head;
    logic            rsp_ok;

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTER; gi++) begin : g_master
            assign m_bundle[gi] = '{
                wdata: m_wdata_i[gi],
                add:   m_add_i[gi],
                wen:   m_wen_i[gi],
                be:    m_be_i[gi],
                size:  m_size_i[gi]
            };
            assign m_gnt_o[gi]     = handshake & (winner == ID_W'(gi));
            assign m_r_valid_o[gi] = rsp_ok & (fifo_head == ID_W'(gi));
        end
    endgenerate

    // First requester at or after rr_q; falls back to rr_q when nobody requests.
    always_comb begin
        scan_id    = rr_q;
        scan_found = 1'b0;
        scan_idx   = 0;
        for (int k = 0; k < N_MASTER; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= N_MASTER) begin
                scan_idx = scan_idx - N_MASTER;
            end
            if (!scan_found && m_req_i[ID_W'(scan_idx)]) begin
                scan_found = 1'b1;
                scan_id    = ID_W'(scan_idx);
            end
        end
    end

    assign winner    = (lock_q == ARB_LOCKED) ? lock_id_q : scan_id;
    assign s_req_o   = (|m_req_i) & ~fifo_full;
    assign handshake = s_req_o & s_gnt_i;
    assign rsp_ok    = s_r_valid_i & ~fifo_empty;

    assign sel_req   = m_bundle[winner];
    assign s_wdata_o = sel_req.wdata;
    assign s_add_o   = sel_req.add;
    assign s_wen_o   = sel_req.wen;
    assign s_be_o    = sel_req.be;
    assign s_size_o  = sel_req.size;

    assign m_r_rdata_o = s_r_rdata_i;
    assign err_o       = err_q;

    always_comb begin
        rr_d      = rr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        err_d     = err_q;
        if (handshake) begin
            rr_d   = (winner == ID_W'(N_MASTER - 1)) ? '0 : winner + ID_W'(1);
            lock_d = ARB_FREE;
        end else if (s_req_o) begin
            lock_d    = ARB_LOCKED;
            lock_id_d = winner;
        end
        if (s_r_valid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            lock_q    <= ARB_FREE;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    lint_id_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (ID_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (handshake),
        .data_i  (winner),
        .pop_i   (s_r_valid_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_lint64_rr_arbiter.sv
// Bench for lint64_rr_arbiter: vector table plus hand sequences for lock, full, error and reset.
// A queue of granted initiator IDs predicts which initiator each response must reach.
module tb_lint64_rr_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        m_req;
    logic [3:0]        m_gnt_o;
    logic [3:0][63:0]  m_wdata;
    logic [3:0][31:0]  m_add;
    logic [3:0]        m_wen;
    logic [3:0][7:0]   m_be;
    logic [3:0]        m_size;
    logic [3:0]        m_r_valid_o;
    logic [63:0]       m_r_rdata_o;
    logic              s_req_o;
    logic              s_gnt;
    logic [63:0]       s_wdata_o;
    logic [31:0]       s_add_o;
    logic              s_wen_o;
    logic [7:0]        s_be_o;
    logic              s_size_o;
    logic              s_r_valid;
    logic [63:0]       s_r_rdata;
    logic              err_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int sb_q[$];
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    lint64_rr_arbiter #(
        .N_MASTER  (4),
        .MAX_OUTST (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_req_i     (m_req),
        .m_gnt_o     (m_gnt_o),
        .m_wdata_i   (m_wdata),
        .m_add_i     (m_add),
        .m_wen_i     (m_wen),
        .m_be_i      (m_be),
        .m_size_i    (m_size),
        .m_r_valid_o (m_r_valid_o),
        .m_r_rdata_o (m_r_rdata_o),
        .s_req_o     (s_req_o),
        .s_gnt_i     (s_gnt),
        .s_wdata_o   (s_wdata_o),
        .s_add_o     (s_add_o),
        .s_wen_o     (s_wen_o),
        .s_be_o      (s_be_o),
        .s_size_o    (s_size_o),
        .s_r_valid_i (s_r_valid),
        .s_r_rdata_i (s_r_rdata),
        .err_o       (err_o)
    );

    typedef struct {
        logic [3:0]  req;
        logic        sgnt;
        logic        rv;
        logic [63:0] rdata;
        logic [3:0]  exp_gnt;
        logic        exp_sreq;
        int          exp_idx;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check combinational outputs 1 ns later.
    task automatic drive_check(input string name, input logic [3:0] req, input logic sgnt,
                               input logic rv, input logic [63:0] rdata,
                               input logic [3:0] exp_gnt, input logic exp_sreq, input int exp_idx);
        logic [3:0] exp_rv;
        int id;
        @(negedge clk);
        m_req     = req;
        s_gnt     = sgnt;
        s_r_valid = rv;
        s_r_rdata = rdata;
        #1;
        exp_rv = 4'b0000;
        check({name, " err"}, 64'(err_o), 64'(exp_err));
        if (rv) begin
            if (sb_q.size() > 0) begin
                id = sb_q.pop_front();
                exp_rv[id] = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
            check({name, " rdata"}, m_r_rdata_o, rdata);
        end
        check({name, " gnt"},    64'(m_gnt_o),     64'(exp_gnt));
        check({name, " sreq"},   64'(s_req_o),     64'(exp_sreq));
        check({name, " rvalid"}, 64'(m_r_valid_o), 64'(exp_rv));
        check({name, " add"},    64'(s_add_o),     64'(m_add[exp_idx]));
        check({name, " fields"}, {s_wdata_o[55:0], s_wen_o, s_size_o, 6'(s_be_o >> 2)},
              {m_wdata[exp_idx][55:0], m_wen[exp_idx], m_size[exp_idx], 6'(m_be[exp_idx] >> 2)});
        for (int i = 0; i < 4; i++) begin
            if (exp_gnt[i]) sb_q.push_back(i);
        end
        $display("[TB] %s req=%b sgnt=%b rv=%b -> gnt=%b sreq=%b rvalid=%b add=%h err=%b",
                 name, req, sgnt, rv, m_gnt_o, s_req_o, m_r_valid_o, s_add_o, err_o);
    endtask

    initial begin
        int gcnt[4];
        logic [3:0] eg;

        m_add   = {32'h0000_5000, 32'h0000_1000, 32'h0000_3000, 32'h0000_4000};
        m_wen   = 4'b0101;
        m_size  = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            m_wdata[i] = {32'h0DA7_A000 + 32'(i), 32'h1234_5678 ^ 32'(i * 3)};
            m_be[i]    = 8'h0F << i;
        end
        m_req = '0; s_gnt = 1'b0; s_r_valid = 1'b0; s_r_rdata = '0;
        rst_n = 1'b0;

        vecs[0] = '{4'b0100, 1'b1, 1'b0, 64'h0,                   4'b0100, 1'b1, 2};
        vecs[1] = '{4'b0000, 1'b1, 1'b1, 64'hDEADBEEF_CAFEBABE,   4'b0000, 1'b0, 3};
        vecs[2] = '{4'b1111, 1'b1, 1'b0, 64'h0,                   4'b1000, 1'b1, 3};
        vecs[3] = '{4'b1111, 1'b1, 1'b1, 64'h0000_0000_0000_0011, 4'b0001, 1'b1, 0};
        vecs[4] = '{4'b1010, 1'b1, 1'b1, 64'h0000_0000_0000_0022, 4'b0010, 1'b1, 1};
        vecs[5] = '{4'b1001, 1'b1, 1'b1, 64'h0000_0000_0000_0033, 4'b1000, 1'b1, 3};
        vecs[6] = '{4'b0000, 1'b1, 1'b1, 64'h0000_0000_0000_0044, 4'b0000, 1'b0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset sreq",   64'(s_req_o),     64'd0);
        check("reset gnt",    64'(m_gnt_o),     64'd0);
        check("reset rvalid", 64'(m_r_valid_o), 64'd0);
        check("reset err",    64'(err_o),       64'd0);
        check("reset add",    64'(s_add_o),     64'(m_add[0]));
        @(negedge clk);
        rst_n = 1'b1;

        // Single initiator, then mixed request patterns
        for (int v = 0; v < 7; v++) begin
            drive_check($sformatf("vec%0d", v), vecs[v].req, vecs[v].sgnt, vecs[v].rv,
                        vecs[v].rdata, vecs[v].exp_gnt, vecs[v].exp_sreq, vecs[v].exp_idx);
        end

        // Fairness: 100 grants with all four requesting and a 1-cycle target
        for (int i = 0; i < 4; i++) gcnt[i] = 0;
        for (int c = 0; c < 100; c++) begin
            eg = 4'b0001 << (c % 4);
            drive_check($sformatf("fair%0d", c), 4'b1111, 1'b1, c > 0, 64'(c),
                        eg, 1'b1, c % 4);
            for (int i = 0; i < 4; i++) if (m_gnt_o[i]) gcnt[i]++;
        end
        drive_check("fair_drain", 4'b0000, 1'b1, 1'b1, 64'h55, 4'b0000, 1'b0, 0);
        for (int i = 0; i < 4; i++) check($sformatf("fair count m%0d", i), 64'(gcnt[i]), 64'd25);

        // Lock: initiator 1 held while initiator 0 joins; 3 follows after the grant
        drive_check("lock1", 4'b1010, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b1, 1);
        drive_check("lock2", 4'b1011, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b1, 1);
        drive_check("lock3", 4'b1011, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b1, 1);
        drive_check("lock4", 4'b1011, 1'b1, 1'b0, 64'h0, 4'b0010, 1'b1, 1);
        drive_check("lock5", 4'b1001, 1'b1, 1'b1, 64'h61, 4'b1000, 1'b1, 3);
        drive_check("lock6", 4'b0001, 1'b1, 1'b1, 64'h62, 4'b0001, 1'b1, 0);
        drive_check("lock7", 4'b0000, 1'b1, 1'b1, 64'h63, 4'b0000, 1'b0, 1);

        // Full: two outstanding, third waits until the cycle after the first response
        drive_check("full1", 4'b0111, 1'b1, 1'b0, 64'h0, 4'b0010, 1'b1, 1);
        drive_check("full2", 4'b0101, 1'b1, 1'b0, 64'h0, 4'b0100, 1'b1, 2);
        drive_check("full3", 4'b0001, 1'b1, 1'b0, 64'h0, 4'b0000, 1'b0, 0);
        drive_check("full4", 4'b0001, 1'b1, 1'b1, 64'h71, 4'b0000, 1'b0, 0);
        drive_check("full5", 4'b0001, 1'b1, 1'b0, 64'h0, 4'b0001, 1'b1, 0);
        drive_check("full6", 4'b0000, 1'b1, 1'b1, 64'h72, 4'b0000, 1'b0, 1);
        drive_check("full7", 4'b0000, 1'b1, 1'b1, 64'h73, 4'b0000, 1'b0, 1);

        // Error: response with nothing outstanding
        drive_check("err1", 4'b0000, 1'b1, 1'b1, 64'h81, 4'b0000, 1'b0, 1);
        drive_check("err2", 4'b0000, 1'b1, 1'b0, 64'h0, 4'b0000, 1'b0, 1);

        // Reset mid-burst
        drive_check("burst1", 4'b1111, 1'b1, 1'b0, 64'h0, 4'b0010, 1'b1, 1);
        drive_check("burst2", 4'b1111, 1'b1, 1'b0, 64'h0, 4'b0100, 1'b1, 2);
        @(negedge clk);
        rst_n = 1'b0; m_req = '0; s_gnt = 1'b0; s_r_valid = 1'b1;
        #1;
        check("midrst err",    64'(err_o),       64'd0);
        check("midrst rvalid", 64'(m_r_valid_o), 64'd0);
        check("midrst sreq",   64'(s_req_o),     64'd0);
        check("midrst add",    64'(s_add_o),     64'(m_add[0]));
        $display("[TB] mid-burst reset applied");
        @(negedge clk);
        rst_n = 1'b1; s_r_valid = 1'b0;
        sb_q.delete();
        exp_err = 1'b0;
        drive_check("post1", 4'b1111, 1'b1, 1'b0, 64'h0, 4'b0001, 1'b1, 0);
        drive_check("post2", 4'b0000, 1'b1, 1'b1, 64'h91, 4'b0000, 1'b0, 1);
        drive_check("post3", 4'b0000, 1'b1, 1'b1, 64'h92, 4'b0000, 1'b0, 1);
        drive_check("post4", 4'b0000, 1'b1, 1'b0, 64'h0, 4'b0000, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
